// File: rtl/pcs_tx_frame_gen.sv
`default_nettype none
// ============================================================================
// Module   : pcs_tx_frame_gen
// Brief    : Bring-up frame source for pcs_tx: preamble, incrementing payload
//            and terminate words, separated by a programmable idle gap.
// Revision : 1.0
// ============================================================================
module pcs_tx_frame_gen #(
   parameter int IS_10G      = 1,
   parameter int DATA_W      = 64,
   parameter int KEEP_W      = DATA_W / 8,
   parameter int LANE0_CNT_N = (IS_10G != 0) ? 2 : 1,
   parameter int LEN_W       = 14,
   parameter int IPG_W       = 8
) (
   input  logic                   clk,
   input  logic                   nreset,
   input  logic                   en_i,
   input  logic [LEN_W-1:0]       len_i,
   input  logic [IPG_W-1:0]       ipg_i,
   input  logic                   err_inj_i,
   input  logic                   ready_i,
   output logic                   ctrl_v_o,
   output logic                   idle_v_o,
   output logic [LANE0_CNT_N-1:0] start_v_o,
   output logic                   term_v_o,
   output logic                   err_v_o,
   output logic [KEEP_W-1:0]      keep_o,
   output logic [DATA_W-1:0]      data_o,
   output logic                   busy_o,
   output logic [31:0]            frame_cnt_o
);

   localparam logic [DATA_W-1:0] c_PREAMBLE = DATA_W'(64'hD555_5555_5555_55FB);
   localparam logic [LEN_W-1:0]  c_MIN_LEN  = LEN_W'(8);
   localparam logic [LEN_W-1:0]  c_BPW      = LEN_W'(KEEP_W);
   localparam logic [IPG_W-1:0]  c_GAP_MAX  = '1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_TERM  = 2'd3
   } state_t;

   state_t           r_state, w_state_nxt;
   logic [IPG_W-1:0] r_gap, w_gap_nxt, w_gap_inc, w_gap_min;
   logic [LEN_W-1:0] r_len, w_len_nxt;
   logic [LEN_W-1:0] r_bcnt, w_bcnt_nxt, w_rem;
   logic             r_err, w_err_nxt;
   logic [31:0]      w_fcnt_nxt;

   logic                   w_ctrl, w_idle, w_term, w_errv;
   logic [LANE0_CNT_N-1:0] w_start;
   logic [KEEP_W-1:0]      w_keep, w_keep_out;
   logic [DATA_W-1:0]      w_pat, w_mask, w_data;

   // Next state is evaluated as if the current word is accepted; the
   // register stage only takes it when ready_i is high.
   always_comb begin
      w_state_nxt = r_state;
      w_gap_nxt   = r_gap;
      w_len_nxt   = r_len;
      w_err_nxt   = r_err;
      w_bcnt_nxt  = r_bcnt;
      w_fcnt_nxt  = frame_cnt_o;
      w_gap_inc   = (r_gap == c_GAP_MAX) ? r_gap : r_gap + 1'b1;
      w_gap_min   = (ipg_i == '0) ? IPG_W'(1) : ipg_i;
      case (r_state)
         S_IDLE: begin
            w_gap_nxt = w_gap_inc;
            if (en_i && (w_gap_inc >= w_gap_min)) begin
               w_state_nxt = S_START;
               w_gap_nxt   = '0;
            end
         end
         S_START: begin
            w_len_nxt   = (len_i < c_MIN_LEN) ? c_MIN_LEN : len_i;
            w_err_nxt   = err_inj_i;
            w_bcnt_nxt  = '0;
            w_state_nxt = S_DATA;
         end
         S_DATA: begin
            w_bcnt_nxt  = r_bcnt + c_BPW;
            w_state_nxt = ((r_len - w_bcnt_nxt) >= c_BPW) ? S_DATA : S_TERM;
         end
         S_TERM: begin
            w_state_nxt = S_IDLE;
            w_gap_nxt   = '0;
            w_fcnt_nxt  = frame_cnt_o + 32'd1;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Word that will be presented once the next state is taken.
   always_comb begin
      w_rem      = w_len_nxt - w_bcnt_nxt;
      w_pat      = '0;
      w_mask     = '0;
      w_keep     = '0;
      for (int i = 0; i < KEEP_W; i++) begin
         w_pat[8*i +: 8]  = 8'(w_bcnt_nxt + LEN_W'(i));
         w_keep[i]        = (LEN_W'(i) < w_rem);
         w_mask[8*i +: 8] = {8{w_keep[i]}};
      end
      w_ctrl     = 1'b1;
      w_idle     = 1'b0;
      w_start    = '0;
      w_term     = 1'b0;
      w_errv     = 1'b0;
      w_keep_out = '0;
      w_data     = '0;
      case (w_state_nxt)
         S_IDLE:  w_idle = 1'b1;
         S_START: begin
            w_start[0] = 1'b1;
            w_data     = c_PREAMBLE;
         end
         S_DATA: begin
            w_ctrl = 1'b0;
            w_data = w_pat;
         end
         S_TERM: begin
            w_term     = 1'b1;
            w_errv     = w_err_nxt;
            w_keep_out = w_keep;
            w_data     = w_pat & w_mask;
         end
         default: w_idle = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         r_state     <= S_IDLE;
         r_gap       <= '0;
         r_len       <= '0;
         r_bcnt      <= '0;
         r_err       <= 1'b0;
         ctrl_v_o    <= 1'b1;
         idle_v_o    <= 1'b1;
         start_v_o   <= '0;
         term_v_o    <= 1'b0;
         err_v_o     <= 1'b0;
         keep_o      <= '0;
         data_o      <= '0;
         busy_o      <= 1'b0;
         frame_cnt_o <= '0;
      end else if (ready_i) begin
         r_state     <= w_state_nxt;
         r_gap       <= w_gap_nxt;
         r_len       <= w_len_nxt;
         r_bcnt      <= w_bcnt_nxt;
         r_err       <= w_err_nxt;
         ctrl_v_o    <= w_ctrl;
         idle_v_o    <= w_idle;
         start_v_o   <= w_start;
         term_v_o    <= w_term;
         err_v_o     <= w_errv;
         keep_o      <= w_keep_out;
         data_o      <= w_data;
         busy_o      <= (w_state_nxt != S_IDLE);
         frame_cnt_o <= w_fcnt_nxt;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pcs_tx_frame_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_pcs_tx_frame_gen
// Brief    : Directed, table-driven bench for pcs_tx_frame_gen.
// Revision : 1.0
// ============================================================================
module tb_pcs_tx_frame_gen;

   localparam int LEN_W = 14;
   localparam int IPG_W = 8;
   localparam logic [63:0] c_PRE = 64'hD555_5555_5555_55FB;
   localparam logic [63:0] c_D0  = 64'h0706_0504_0302_0100;
   localparam logic [63:0] c_D1  = 64'h0F0E_0D0C_0B0A_0908;
   localparam logic [63:0] c_T21 = 64'h0000_0014_1312_1110;

   typedef enum int {K_IDLE, K_START, K_DATA, K_TERM} kind_t;

   typedef struct {
      logic             en;
      logic [LEN_W-1:0] len;
      logic [IPG_W-1:0] ipg;
      logic             rdy;
      kind_t            kind;
      logic [63:0]      data;
      logic [7:0]       keep;
      logic             busy;
      logic [31:0]      fcnt;
   } vec_t;

   logic             clk = 1'b0;
   logic             nreset;
   logic             en_i;
   logic [LEN_W-1:0] len_i;
   logic [IPG_W-1:0] ipg_i;
   logic             err_inj_i;
   logic             ready_i;
   logic             ctrl_v_o, idle_v_o, term_v_o, err_v_o, busy_o;
   logic [1:0]       start_v_o;
   logic [7:0]       keep_o;
   logic [63:0]      data_o;
   logic [31:0]      frame_cnt_o;

   int checks = 0;
   int errors = 0;
   vec_t tbl[$];

   pcs_tx_frame_gen dut (
      .clk        (clk),
      .nreset     (nreset),
      .en_i       (en_i),
      .len_i      (len_i),
      .ipg_i      (ipg_i),
      .err_inj_i  (err_inj_i),
      .ready_i    (ready_i),
      .ctrl_v_o   (ctrl_v_o),
      .idle_v_o   (idle_v_o),
      .start_v_o  (start_v_o),
      .term_v_o   (term_v_o),
      .err_v_o    (err_v_o),
      .keep_o     (keep_o),
      .data_o     (data_o),
      .busy_o     (busy_o),
      .frame_cnt_o(frame_cnt_o)
   );

   always #5 clk = ~clk;

   function automatic logic [78:0] act_word();
      return {ctrl_v_o, idle_v_o, start_v_o, term_v_o, err_v_o, keep_o, data_o, busy_o};
   endfunction

   function automatic logic [78:0] exp_word(kind_t k, logic [63:0] d, logic [7:0] kp,
                                            logic e, logic b);
      case (k)
         K_IDLE:  return {1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 8'h00, 64'h0, b};
         K_START: return {1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 8'h00, c_PRE, b};
         K_DATA:  return {1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00, d, b};
         default: return {1'b1, 1'b0, 2'b00, 1'b1, e, kp, d, b};
      endcase
   endfunction

   function automatic vec_t mk(int en, int len, int ipg, int rdy, kind_t k,
                               logic [63:0] d, int kp, int b, int fc);
      vec_t v;
      v.en = (en != 0);  v.len = LEN_W'(len);  v.ipg = IPG_W'(ipg);
      v.rdy = (rdy != 0); v.kind = k; v.data = d; v.keep = 8'(kp);
      v.busy = (b != 0); v.fcnt = 32'(fc);
      return v;
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      nreset = 1'b0; en_i = 1'b0; len_i = 14'd16; ipg_i = 8'd3;
      err_inj_i = 1'b0; ready_i = 1'b1;

      // ---------------- reset state ----------------
      repeat (3) step();
      check("reset_word", 128'(act_word()), 128'(exp_word(K_IDLE, 64'h0, 8'h0, 1'b0, 1'b0)));
      check("reset_fcnt", 128'(frame_cnt_o), 128'(0));
      #4 nreset = 1'b1;

      // ---------------- directed table ----------------
      for (int k = 0; k < 20; k++) tbl.push_back(mk(0, 16, 3, 1, K_IDLE, 64'h0, 0, 0, 0));
      tbl.push_back(mk(1, 16, 3, 1, K_START, 64'h0, 0, 1, 0));
      tbl.push_back(mk(1, 16, 3, 1, K_DATA,  c_D0,  0, 1, 0));
      tbl.push_back(mk(1, 16, 3, 0, K_DATA,  c_D0,  0, 1, 0));
      tbl.push_back(mk(1, 16, 3, 1, K_DATA,  c_D1,  0, 1, 0));
      tbl.push_back(mk(1, 16, 3, 1, K_TERM,  64'h0, 0, 1, 0));
      tbl.push_back(mk(1, 16, 3, 1, K_IDLE,  64'h0, 0, 0, 1));
      tbl.push_back(mk(1, 21, 3, 1, K_IDLE,  64'h0, 0, 0, 1));
      tbl.push_back(mk(1, 21, 3, 1, K_IDLE,  64'h0, 0, 0, 1));
      tbl.push_back(mk(1, 21, 3, 1, K_START, 64'h0, 0, 1, 1));
      tbl.push_back(mk(1, 21, 3, 0, K_START, 64'h0, 0, 1, 1));
      tbl.push_back(mk(1, 21, 3, 1, K_DATA,  c_D0,  0, 1, 1));
      tbl.push_back(mk(1, 21, 3, 1, K_DATA,  c_D1,  0, 1, 1));
      tbl.push_back(mk(1, 21, 3, 1, K_TERM,  c_T21, 8'h1F, 1, 1));
      tbl.push_back(mk(1,  3, 3, 0, K_TERM,  c_T21, 8'h1F, 1, 1));
      tbl.push_back(mk(1,  3, 3, 1, K_IDLE,  64'h0, 0, 0, 2));
      tbl.push_back(mk(1,  3, 3, 1, K_IDLE,  64'h0, 0, 0, 2));
      tbl.push_back(mk(1,  3, 3, 1, K_IDLE,  64'h0, 0, 0, 2));
      tbl.push_back(mk(1,  3, 3, 1, K_START, 64'h0, 0, 1, 2));
      tbl.push_back(mk(1,  3, 3, 1, K_DATA,  c_D0,  0, 1, 2));
      tbl.push_back(mk(1,  3, 0, 1, K_TERM,  64'h0, 0, 1, 2));
      tbl.push_back(mk(1,  3, 0, 1, K_IDLE,  64'h0, 0, 0, 3));
      tbl.push_back(mk(1,  8, 0, 1, K_START, 64'h0, 0, 1, 3));
      tbl.push_back(mk(1,  8, 0, 1, K_DATA,  c_D0,  0, 1, 3));
      tbl.push_back(mk(0, 100, 0, 1, K_TERM, 64'h0, 0, 1, 3));
      tbl.push_back(mk(0, 100, 0, 1, K_IDLE, 64'h0, 0, 0, 4));
      tbl.push_back(mk(0, 100, 0, 1, K_IDLE, 64'h0, 0, 0, 4));
      tbl.push_back(mk(0, 100, 0, 0, K_IDLE, 64'h0, 0, 0, 4));

      foreach (tbl[k]) begin
         en_i = tbl[k].en; len_i = tbl[k].len; ipg_i = tbl[k].ipg; ready_i = tbl[k].rdy;
         step();
         check($sformatf("vec%0d_word", k), 128'(act_word()),
               128'(exp_word(tbl[k].kind, tbl[k].data, tbl[k].keep, 1'b0, tbl[k].busy)));
         check($sformatf("vec%0d_fcnt", k), 128'(frame_cnt_o), 128'(tbl[k].fcnt));
      end

      // ---------------- len=300 stream under backpressure ----------------
      begin
         logic [78:0] cur;
         logic [31:0] cur_fc;
         logic [7:0]  exp_b;
         logic [63:0] last_term;
         logic        rdy, in_frame;
         int cyc, frames, ndata, stall_left;
         int hold_bad, order_bad, byte_bad, term_bad;
         cyc = 0; frames = 0; ndata = 0; stall_left = 0; exp_b = 8'h00;
         hold_bad = 0; order_bad = 0; byte_bad = 0; term_bad = 0;
         in_frame = 1'b0; last_term = 64'h0;
         en_i = 1'b1; len_i = 14'd300; ipg_i = 8'd2;
         cur = act_word(); cur_fc = frame_cnt_o;
         while (frames < 3 && cyc < 4000) begin
            if (stall_left > 0) begin
               rdy = 1'b0; stall_left--;
            end else if ($urandom_range(0, 15) == 0) begin
               rdy = 1'b0; stall_left = $urandom_range(0, 3);
            end else begin
               rdy = ((cyc % 32) != 31);
            end
            ready_i = rdy;
            step();
            if (!rdy) begin
               if (act_word() !== cur || frame_cnt_o !== cur_fc) hold_bad++;
            end else if (cur[76:75] == 2'b01 && cur[78]) begin
               if (in_frame) order_bad++;
               in_frame = 1'b1; exp_b = 8'h00; ndata = 0;
            end else if (!cur[78]) begin
               if (!in_frame) order_bad++;
               for (int i = 0; i < 8; i++) begin
                  if (cur[1 + 8*i +: 8] !== exp_b) byte_bad++;
                  exp_b = exp_b + 8'd1;
               end
               ndata++;
            end else if (cur[74]) begin
               if (!in_frame) order_bad++;
               if (ndata != 37 || cur[72:65] !== 8'h0F) term_bad++;
               last_term = cur[64:1];
               in_frame = 1'b0;
               frames++;
            end else if (in_frame) begin
               order_bad++;
            end
            cur = act_word(); cur_fc = frame_cnt_o;
            cyc++;
         end
         check("stream_frames", 128'(frames), 128'(3));
         check("stream_hold", 128'(hold_bad), 128'(0));
         check("stream_order", 128'(order_bad), 128'(0));
         check("stream_bytes", 128'(byte_bad), 128'(0));
         check("stream_term_len_keep", 128'(term_bad), 128'(0));
         check("stream_term_data", 128'(last_term), 128'(64'h0000_0000_2B2A_2928));
         check("stream_fcnt", 128'(frame_cnt_o), 128'(7));
      end

      // ---------------- error injection and en drop ----------------
      ready_i = 1'b1; len_i = 14'd8; ipg_i = 8'd1; err_inj_i = 1'b1; en_i = 1'b1;
      step();
      check("errN_start", 128'(act_word()), 128'(exp_word(K_START, 64'h0, 8'h0, 1'b0, 1'b1)));
      step();
      err_inj_i = 1'b0;
      check("errN_data", 128'(act_word()), 128'(exp_word(K_DATA, c_D0, 8'h0, 1'b0, 1'b1)));
      step();
      check("errN_term", 128'(act_word()), 128'(exp_word(K_TERM, 64'h0, 8'h0, 1'b1, 1'b1)));
      step();
      check("errN_idle", 128'(act_word()), 128'(exp_word(K_IDLE, 64'h0, 8'h0, 1'b0, 1'b0)));
      check("errN_fcnt", 128'(frame_cnt_o), 128'(8));
      step();
      check("errN1_start", 128'(act_word()), 128'(exp_word(K_START, 64'h0, 8'h0, 1'b0, 1'b1)));
      step();
      check("errN1_data", 128'(act_word()), 128'(exp_word(K_DATA, c_D0, 8'h0, 1'b0, 1'b1)));
      en_i = 1'b0;
      step();
      check("errN1_term", 128'(act_word()), 128'(exp_word(K_TERM, 64'h0, 8'h0, 1'b0, 1'b1)));
      begin
         int bad;
         bad = 0;
         repeat (20) begin
            step();
            if (act_word() !== exp_word(K_IDLE, 64'h0, 8'h0, 1'b0, 1'b0)) bad++;
         end
         check("en_off_idle", 128'(bad), 128'(0));
         check("en_off_fcnt", 128'(frame_cnt_o), 128'(9));
      end

      // ---------------- asynchronous reset mid-frame ----------------
      en_i = 1'b1; len_i = 14'd300; ipg_i = 8'd2;
      step();
      step();
      step();
      check("pre_rst_data", 128'(act_word()), 128'(exp_word(K_DATA, c_D1, 8'h0, 1'b0, 1'b1)));
      #2 nreset = 1'b0;
      #1;
      check("rst_async_word", 128'(act_word()), 128'(exp_word(K_IDLE, 64'h0, 8'h0, 1'b0, 1'b0)));
      check("rst_async_fcnt", 128'(frame_cnt_o), 128'(0));
      #1 nreset = 1'b1;
      step();
      check("post_rst_gap", 128'(act_word()), 128'(exp_word(K_IDLE, 64'h0, 8'h0, 1'b0, 1'b0)));
      step();
      check("post_rst_start", 128'(act_word()), 128'(exp_word(K_START, 64'h0, 8'h0, 1'b0, 1'b1)));
      step();
      check("post_rst_data", 128'(act_word()), 128'(exp_word(K_DATA, c_D0, 8'h0, 1'b0, 1'b1)));
      check("post_rst_fcnt", 128'(frame_cnt_o), 128'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pcs_tx_frame_gen.md
Name: pcs_tx_frame_gen

Overview:
- Frame source sitting directly upstream of pcs_tx, in the gx_tx_par_clk domain. It replaces the RX->TX loopback as the TX stimulus for link bring-up.
- Drives the pcs_tx input interface (ctrl/idle/start/term/err/keep/data) with back-to-back Ethernet-like frames of programmable length and incrementing payload, separated by a programmable idle gap.
- Honours pcs_tx ready_o, which pauses for gearbox slips.
- Counts sent frames for bring-up status.

Parameters:
- IS_10G, 1, selects 10G interface; start vector width is 2 when set, else 1.
- DATA_W, 64, data bus width in bits.
- KEEP_W, DATA_W/8, byte keep width.
- LANE0_CNT_N, IS_10G ? 2 : 1, width of start_v_o.
- LEN_W, 14, width of frame payload length in bytes.
- IPG_W, 8, width of the inter-frame idle cycle count.

Ports:
- clk  in  1  gx_tx_par_clk.
- nreset  in  1  asynchronous active-low reset.
- en_i  in  1  generator enable.
- len_i  in  LEN_W  payload length in bytes (preamble excluded).
- ipg_i  in  IPG_W  idle cycles between frames.
- err_inj_i  in  1  mark the next frame errored.
- ready_i  in  1  pcs_tx ready_o; outputs are accepted only when high.
- ctrl_v_o  out  1  control block.
- idle_v_o  out  1  idle block.
- start_v_o  out  LANE0_CNT_N  start position; bit0 means lane 0.
- term_v_o  out  1  terminate block.
- err_v_o  out  1  error block.
- keep_o  out  KEEP_W  valid payload bytes on the term cycle.
- data_o  out  DATA_W  block data.
- busy_o  out  1  frame in progress (START..TERM).
- frame_cnt_o  out  32  completed frames; wraps.

Behaviour:
- Single clock. Asynchronous active-low reset. All state is in registers and every output is registered.
- Reset values:
  - ctrl_v_o=1, idle_v_o=1; all other flags 0.
  - keep_o=0, data_o=0, busy_o=0, frame_cnt_o=0.
  - FSM in IDLE with gap counter=0.
- Handshake:
  - The current output word is consumed on a clk edge with ready_i=1.
  - With ready_i=0 the FSM, counters and all outputs hold unchanged. No word is skipped or duplicated.
- FSM IDLE:
  - Drives the idle word: ctrl=1, idle=1, data=0, keep=0.
  - The gap counter increments per accepted idle word.
  - Transition to START when en_i=1 and gap counter >= max(ipg_i,1). The gap counter clears on transition.
- FSM START (one accepted word):
  - ctrl=1, start_v_o=1 (lane 0; bit1 never set), data_o=64'hD555_5555_5555_55FB.
  - len_i and err_inj_i are sampled when this word is accepted.
  - Effective length L = len_i clamped to a minimum of 8.
  - Byte counter cleared; busy_o=1.
- FSM DATA:
  - Emitted while remaining bytes >= 8.
  - ctrl=0; data byte i = (byte counter + i) mod 256, byte 0 in data_o[7:0].
  - Byte counter += 8 per accepted word.
- FSM TERM (one accepted word):
  - ctrl=1, term=1, keep_o = (1<<r)-1 with r = L mod 8.
  - Bytes below r continue the incrementing pattern; bytes at r and above are 0.
  - r=0 gives keep_o=0 (terminate in lane 0).
  - err_v_o=1 on this word if the sampled err_inj_i was set.
  - On acceptance: frame_cnt_o+1 (wrap 2^32-1 -> 0), busy_o=0, return to IDLE with the gap counter at 0.
- en_i deasserted mid-frame: the frame completes normally, then the block stays in IDLE.
- len_i / ipg_i / err_inj_i changes mid-frame have no effect until the next START acceptance. ipg_i is re-read continuously in IDLE.
- Byte counter width is LEN_W; the pattern is the counter's low 8 bits, wrapping at 256.
- Reset asserted mid-frame: immediate return to reset values. No term word is emitted and frame_cnt_o is not incremented.
- Exactly one of {idle, start, data, term} is active per word; err_v_o is only ever set with term.

Test Plan:
- Reset release, en_i=0, ready_i=1 for 20 cycles -> idle word every cycle; frame_cnt_o=0; busy_o=0.
- en_i=1, len_i=16, ipg_i=3 -> 3 idle words, START (data 64'hD5555555555555FB), DATA 0x0706..00, DATA 0x0F0E..08, TERM keep=0x00; frame_cnt_o=1; pattern repeats after 3 idles.
- len_i=21 -> 2 DATA words, TERM keep=0x1F with data bytes 0x10..0x14 and upper 3 bytes 0; len_i=3 -> clamped, 1 DATA word (0x00..0x07), TERM keep=0x00.
- ready_i toggled low 1 cycle of every 32 (plus random low stretches) during len_i=300 frames -> byte stream gapless and monotonic mod 256, no duplicates; 38 words per frame (START + 37 DATA) plus TERM with keep=0x0F.
- err_inj_i=1 at START of frame N only -> err_v_o=1 on frame N TERM only; en_i dropped during frame N+1 DATA -> frame N+1 completes, then idle forever.
- nreset pulsed low mid-DATA -> outputs return to the idle word asynchronously; frame_cnt_o=0; next frame starts with pattern byte 0x00 after the gap.
